// File: rtl/interrupt_controller_core.sv
// interrupt_controller_core
// Four-source, fixed-priority interrupt controller with a req/ack handshake.
// Rising edges on irq[3:0] latch into a pending set. Source 3 has the highest
// priority. One interrupt is presented at a time, and an acknowledge edge
// retires it.
// Optional feature: define INTC_MASK_EN to add the irq_mask port
// (1 = source disabled). Masked sources still latch pending.
module interrupt_controller_core (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] irq,
`ifdef INTC_MASK_EN
  input  logic [3:0] irq_mask,
`endif
  input  logic       int_ack,
  output logic       int_req,
  output logic [1:0] int_id
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t     state_reg;
  state_t     state_next;

  logic [3:0] irq_d;
  logic [3:0] pending;
  logic [3:0] pending_next;
  logic [3:0] rise;
  logic [3:0] clr;
  logic [3:0] eligible;
  logic       int_ack_d;
  logic       ack_edge;
  logic       ack_clear;
  logic       any_eligible;
  logic       take_new;
  logic [1:0] cur_id;
  logic [1:0] sel_id;

  // Only sources that are not masked may start a new request.
`ifdef INTC_MASK_EN
  assign eligible = pending & ~irq_mask;
`else
  assign eligible = pending;
`endif

  assign any_eligible = |eligible;
  assign ack_edge     = int_ack & ~int_ack_d;
  assign ack_clear    = (state_reg == ACTIVE) & ack_edge;
  assign take_new     = (state_reg == IDLE) & any_eligible;

  // Per-source pending bit. A new rising edge beats a same-cycle ack clear.
  for (genvar gi = 0; gi < 4; gi++) begin : g_src
    assign rise[gi]         = irq[gi] & ~irq_d[gi];
    assign clr[gi]          = ack_clear & (cur_id == 2'(gi));
    assign pending_next[gi] = rise[gi] | (pending[gi] & ~clr[gi]);
  end

  // Fixed-priority select. A higher index overrides a lower one.
  always_comb begin
    sel_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (eligible[i]) begin
        sel_id = i[1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic. Only an ack edge retires an interrupt, so a held
  // ack retires just one.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_eligible) state_next = ACTIVE;
      ACTIVE:  if (ack_edge)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM output logic. The request comes straight from the state register.
  always_comb begin
    int_req = (state_reg == ACTIVE);
  end

  // Datapath registers: input history, pending set and the in-service id.
  // cur_id and int_id only load on IDLE->ACTIVE, so in ACTIVE they are locked
  // against later higher-priority edges, and in IDLE they hold their last value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_d     <= 4'd0;
      int_ack_d <= 1'b0;
      pending   <= 4'd0;
      cur_id    <= 2'd0;
      int_id    <= 2'd0;
    end else begin
      irq_d     <= irq;
      int_ack_d <= int_ack;
      pending   <= pending_next;
      if (take_new) begin
        cur_id <= sel_id;
        int_id <= sel_id;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller_core.sv
// Testbench for interrupt_controller_core: directed scenarios followed by
// random traffic, checked every cycle against a service-level reference model.
// Define INTC_MASK_EN to also exercise the irq_mask port.
module tb_interrupt_controller_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq;
  logic [3:0] irq_mask;
  logic       int_ack;
  logic       int_req;
  logic [1:0] int_id;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: pending set, the source in service (-1 = none),
  // the last presented id, and the previous input values.
  bit m_pend [4];
  bit m_pirq [4];
  bit m_pack;
  int m_srv;
  int m_id;

  interrupt_controller_core dut (
    .clk     (clk),
    .rst     (rst),
    .irq     (irq),
`ifdef INTC_MASK_EN
    .irq_mask(irq_mask),
`endif
    .int_ack (int_ack),
    .int_req (int_req),
    .int_id  (int_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    check_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Advance the model by one clock edge, using the inputs applied before that edge.
  task automatic model_step();
    bit new_edge [4];
    if (!rst) begin
      for (int n = 0; n < 4; n++) begin
        m_pend[n] = 1'b0;
        m_pirq[n] = 1'b0;
      end
      m_pack = 1'b0;
      m_srv  = -1;
      m_id   = 0;
    end else begin
      for (int n = 0; n < 4; n++) new_edge[n] = irq[n] && !m_pirq[n];
      if (m_srv >= 0) begin
        if (int_ack && !m_pack) begin
          $display("serviced source %0d at %0t", m_srv, $time);
          m_pend[m_srv] = 1'b0;
          m_srv = -1;
        end
      end else begin
        for (int n = 3; n >= 0; n--) begin
          if (m_pend[n] && !irq_mask[n]) begin
            m_srv = n;
            m_id  = n;
            break;
          end
        end
      end
      for (int n = 0; n < 4; n++) begin
        if (new_edge[n]) m_pend[n] = 1'b1;
        m_pirq[n] = irq[n];
      end
      m_pack = int_ack;
    end
  endtask

  // One clock: update the model at the edge, then compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("int_req", {7'd0, int_req}, (m_srv >= 0) ? 8'd1 : 8'd0);
    chk("int_id", {6'd0, int_id}, m_id[7:0]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    cycle();
    int_ack = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    irq      = 4'd0;
    irq_mask = 4'd0;
    int_ack  = 1'b0;
    m_srv    = -1;
    m_id     = 0;
    m_pack   = 1'b0;
    run(3);
    chk("reset_req", {7'd0, int_req}, 8'd0);
    chk("reset_id", {6'd0, int_id}, 8'd0);
    rst = 1'b1;
    run(2);

    // Single source with a held level
    irq = 4'b0001;
    cycle();
    chk("single_req_first_edge", {7'd0, int_req}, 8'd0);
    cycle();
    chk("single_req", {7'd0, int_req}, 8'd1);
    chk("single_id", {6'd0, int_id}, 8'd0);
    ack_pulse();
    chk("single_ack_drop", {7'd0, int_req}, 8'd0);
    run(4);
    chk("single_no_rerequest", {7'd0, int_req}, 8'd0);
    irq = 4'd0;
    run(2);

    // Simultaneous sources are serviced in priority order
    irq = 4'b0110;
    run(2);
    chk("simul_first_id", {6'd0, int_id}, 8'd2);
    ack_pulse();
    chk("simul_gap", {7'd0, int_req}, 8'd0);
    cycle();
    chk("simul_second_req", {7'd0, int_req}, 8'd1);
    chk("simul_second_id", {6'd0, int_id}, 8'd1);
    ack_pulse();
    run(2);
    chk("simul_done", {7'd0, int_req}, 8'd0);
    irq = 4'd0;
    run(2);

    // A held ack retires only one interrupt
    irq = 4'b1010;
    run(2);
    chk("held_first_id", {6'd0, int_id}, 8'd3);
    irq = 4'd0;
    int_ack = 1'b1;
    run(5);
    chk("held_src1_still_req", {7'd0, int_req}, 8'd1);
    chk("held_src1_id", {6'd0, int_id}, 8'd1);
    int_ack = 1'b0;
    cycle();
    ack_pulse();
    chk("held_repulse_clear", {7'd0, int_req}, 8'd0);
    run(2);

    // The in-service id is locked against a higher-priority arrival
    irq = 4'b0010;
    run(2);
    irq = 4'b1010;
    run(3);
    chk("lock_id", {6'd0, int_id}, 8'd1);
    ack_pulse();
    chk("lock_gap", {7'd0, int_req}, 8'd0);
    cycle();
    chk("lock_next_id", {6'd0, int_id}, 8'd3);
    ack_pulse();
    irq = 4'd0;
    run(2);

    // Reset while ACTIVE discards the in-service interrupt
    irq = 4'b0001;
    run(2);
    chk("rst_mid_pre", {7'd0, int_req}, 8'd1);
    rst = 1'b0;
    irq = 4'd0;
    cycle();
    chk("rst_mid_req", {7'd0, int_req}, 8'd0);
    chk("rst_mid_id", {6'd0, int_id}, 8'd0);
    rst = 1'b1;
    run(3);
    chk("rst_mid_pending_gone", {7'd0, int_req}, 8'd0);

    // A line already high at reset release counts as a rising edge
    rst = 1'b0;
    irq = 4'b0100;
    cycle();
    rst = 1'b1;
    run(2);
    chk("release_edge_req", {7'd0, int_req}, 8'd1);
    chk("release_edge_id", {6'd0, int_id}, 8'd2);
    ack_pulse();
    irq = 4'd0;
    run(2);

    // A new edge on the in-service source, coinciding with its ack, wins
    irq = 4'b0001;
    run(2);
    irq = 4'd0;
    cycle();
    irq = 4'b0001;
    ack_pulse();
    cycle();
    chk("set_wins_req", {7'd0, int_req}, 8'd1);
    chk("set_wins_id", {6'd0, int_id}, 8'd0);
    ack_pulse();
    irq = 4'd0;
    run(2);

`ifdef INTC_MASK_EN
    // A masked source stays pending and requests once unmasked
    irq_mask = 4'b0100;
    irq = 4'b0100;
    run(3);
    chk("mask_no_req", {7'd0, int_req}, 8'd0);
    irq_mask = 4'd0;
    cycle();
    chk("unmask_req", {7'd0, int_req}, 8'd1);
    chk("unmask_id", {6'd0, int_id}, 8'd2);
    irq_mask = 4'b0100;
    run(2);
    chk("mask_in_service_keeps_req", {7'd0, int_req}, 8'd1);
    ack_pulse();
    irq_mask = 4'd0;
    irq = 4'd0;
    run(2);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
      end
      int_ack = ($urandom_range(0, 2) == 0);
`ifdef INTC_MASK_EN
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 9) == 0) irq_mask[b] = ~irq_mask[b];
      end
`endif
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
